line_fetch_sched: RTL

Sequences the shared framebuffer RAM so each 640-pixel display line is fetched during horizontal blanking and presented as a 640-bit line vector to the VGA pixel stage. Arbitrates the single RAM port between display fetches (priority) and a pixel-writer port. Double-buffered: fetches fill a shadow register; a swap pulse at line start publishes it.

---
 rtl/line_fetch_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/line_fetch_sched.sv
// Fetches one display line from the shared framebuffer RAM into a shadow register and publishes it on swap.
// Latency: 21 cycles from the fetch_req sample to shadow ready; 1 cycle for a writer access; outputs registered.
// Backpressure: writer holds wr_req until wr_ack, display fetches take priority; fetch_req while busy is dropped (overrun).
module line_fetch_sched #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 20,
    parameter int LINES          = 480,
    parameter int ADDR_W         = 14
) (
    input  logic                               dclk,
    input  logic                               clr,
    input  logic                               fetch_req,
    input  logic [8:0]                         fetch_row,
    input  logic                               swap,
    output logic                               ram_en,
    output logic                               ram_we,
    output logic [ADDR_W-1:0]                  ram_addr,
    output logic [WORD_W-1:0]                  ram_wdata,
    input  logic [WORD_W-1:0]                  ram_rdata,
    input  logic                               wr_req,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [WORD_W-1:0]                  wr_data,
    output logic                               wr_ack,
    output logic [WORD_W*WORDS_PER_LINE-1:0]   line,
    output logic                               fetch_busy,
    output logic                               underrun,
    output logic                               overrun
);

    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int CNT_W  = $clog2(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

    state_t              state, state_nxt;
    logic [LINE_W-1:0]   shadow;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                ready, ready_nxt;
    logic                pend, pend_nxt;
    logic [8:0]          pend_row, pend_row_nxt;
    logic                rd_vld;
    logic [CNT_W-1:0]    rd_idx;

    logic                en_nxt, we_nxt, ack_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [WORD_W-1:0]   wdata_nxt;
    logic                under_nxt, over_nxt;
    logic                publish, blank_clr;
    logic [8:0]          start_row;
    logic                start_blank;
    logic [ADDR_W-1:0]   start_base;

    // A fresh fetch_req takes precedence over a request parked during a writer access.
    always_comb begin
        start_row   = fetch_req ? fetch_row : pend_row;
        start_blank = (int'(start_row) >= LINES);
        // Constant multiply reduces to shift-and-add (row*16 + row*4 for 20 words).
        start_base  = ADDR_W'(start_row) * ADDR_W'(WORDS_PER_LINE);
    end

    // State register.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and next-output decode; every registered output is computed here one cycle ahead.
    always_comb begin
        state_nxt    = state;
        en_nxt       = 1'b0;
        we_nxt       = 1'b0;
        ack_nxt      = 1'b0;
        addr_nxt     = ram_addr;
        wdata_nxt    = ram_wdata;
        cnt_nxt      = cnt;
        ready_nxt    = ready;
        pend_nxt     = pend;
        pend_row_nxt = pend_row;
        under_nxt    = underrun;
        over_nxt     = overrun;
        publish      = 1'b0;
        blank_clr    = 1'b0;

        // Swap publishes only a completed shadow; anything else is a missed line.
        if (swap) begin
            if (ready) begin
                publish   = 1'b1;
                ready_nxt = 1'b0;
            end else begin
                under_nxt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (fetch_req || pend) begin
                    pend_nxt = 1'b0;
                    if (start_blank) begin
                        // Rows below the visible area are blank: no RAM traffic.
                        blank_clr = 1'b1;
                        ready_nxt = 1'b1;
                    end else begin
                        state_nxt = FETCH;
                        en_nxt    = 1'b1;
                        addr_nxt  = start_base;
                        cnt_nxt   = '0;
                        ready_nxt = 1'b0;
                    end
                end else if (wr_req) begin
                    state_nxt = WRITE;
                    en_nxt    = 1'b1;
                    we_nxt    = 1'b1;
                    ack_nxt   = 1'b1;
                    addr_nxt  = wr_addr;
                    wdata_nxt = wr_data;
                end
            end
            FETCH: begin
                if (fetch_req) over_nxt = 1'b1;
                if (cnt == LAST_WORD) begin
                    state_nxt = DRAIN;
                end else begin
                    en_nxt   = 1'b1;
                    addr_nxt = ram_addr + ADDR_W'(1);
                    cnt_nxt  = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                // Last read word lands this cycle; shadow is complete at the edge.
                if (fetch_req) over_nxt = 1'b1;
                state_nxt = IDLE;
                ready_nxt = 1'b1;
            end
            WRITE: begin
                if (fetch_req) begin
                    pend_nxt     = 1'b1;
                    pend_row_nxt = fetch_row;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, control state and the read-capture pipeline.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            wr_ack     <= 1'b0;
            fetch_busy <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
            cnt        <= '0;
            ready      <= 1'b0;
            pend       <= 1'b0;
            pend_row   <= '0;
            rd_vld     <= 1'b0;
            rd_idx     <= '0;
        end else begin
            ram_en     <= en_nxt;
            ram_we     <= we_nxt;
            ram_addr   <= addr_nxt;
            ram_wdata  <= wdata_nxt;
            wr_ack     <= ack_nxt;
            fetch_busy <= (state_nxt == FETCH) || (state_nxt == DRAIN);
            underrun   <= under_nxt;
            overrun    <= over_nxt;
            cnt        <= cnt_nxt;
            ready      <= ready_nxt;
            pend       <= pend_nxt;
            pend_row   <= pend_row_nxt;
            // A read issued this cycle returns data next cycle, tagged with its word slot.
            rd_vld     <= ram_en & ~ram_we;
            rd_idx     <= cnt;
        end
    end

    // Shadow fill from returning read data, and publish to the visible line.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            shadow <= '0;
            line   <= '0;
        end else begin
            if (blank_clr)   shadow <= '0;
            else if (rd_vld) shadow[int'(rd_idx)*WORD_W +: WORD_W] <= ram_rdata;
            if (publish)     line <= shadow;
        end
    end

endmodule
